// File: rtl/preamble_pkg.sv
// Shared types and sizing helpers for the preamble detect / burst gate path.
package preamble_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELAY   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } gate_state_e;

  localparam int STAT_W = 16;

  // Counter width able to hold 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/preamble_burst_gate_axis_out_reg.sv
// Single-entry AXI-stream output register (tdata/tlast) with occupancy-gated
// ready and synchronous clear.
module axis_out_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] s_tdata_i,
  input  logic             s_tlast_i,
  input  logic             s_tvalid_i,
  output logic             s_tready_o,
  output logic [WIDTH-1:0] m_tdata_o,
  output logic             m_tlast_o,
  output logic             m_tvalid_o,
  input  logic             m_tready_i
);

  logic [WIDTH-1:0] data_q;
  logic             last_q;
  logic             valid_q;

  assign s_tready_o = ~valid_q | m_tready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (clear_i) begin
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (s_tvalid_i && s_tready_o) begin
      data_q  <= s_tdata_i;
      last_q  <= s_tlast_i;
      valid_q <= 1'b1;
    end else if (m_tready_i) begin
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end
  end

  assign m_tdata_o  = data_q;
  assign m_tlast_o  = last_q;
  assign m_tvalid_o = valid_q;

endmodule

// File: rtl/preamble_burst_gate.sv
// Gates the decimated IQ stream into one framed burst per preamble trigger.
//   state   | meaning
//   IDLE    | drop beats, wait for peak_stb
//   DELAY   | drop OFFSET accepted beats
//   CAPTURE | forward BURST_LEN beats (or up to in_tlast)
//   HOLD    | drop HOLDOFF accepted beats, triggers counted as missed
module preamble_burst_gate
  import preamble_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_OFFSET = 4095,
  parameter int OFFSET     = 4092,
  parameter int MAX_BURST  = 65535,
  parameter int BURST_LEN  = 1024,
  parameter int HOLDOFF    = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic [2*DATA_WIDTH-1:0] in_tdata,
  input  logic                    in_tvalid,
  input  logic                    in_tlast,
  output logic                    in_tready,
  input  logic                    peak_stb,
  output logic [2*DATA_WIDTH-1:0] out_tdata,
  output logic                    out_tvalid,
  output logic                    out_tlast,
  input  logic                    out_tready,
  output logic                    busy,
  output logic [STAT_W-1:0]       burst_count,
  output logic [STAT_W-1:0]       missed_count,
  output logic                    truncated
);

  localparam int OFF_W = cnt_width(MAX_OFFSET);
  localparam int BST_W = cnt_width(MAX_BURST);
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'((OFFSET > 0) ? OFFSET - 1 : 0);
  localparam logic [BST_W-1:0] BST_LAST = BST_W'((BURST_LEN > 0) ? BURST_LEN - 1 : 0);
  localparam logic [OFF_W-1:0] HLD_LAST = OFF_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  gate_state_e       state_q, state_d;
  logic [OFF_W-1:0]  off_cnt_q, off_cnt_d;
  logic [OFF_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [BST_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [STAT_W-1:0] burst_count_q, burst_count_d;
  logic [STAT_W-1:0] missed_count_q, missed_count_d;
  logic              truncated_q, truncated_d;
  logic              reg_ready;
  logic              accept;
  logic              cap_last;

  assign in_tready = (state_q == CAPTURE) ? reg_ready : 1'b1;
  assign accept    = in_tvalid & in_tready;
  assign cap_last  = (beat_cnt_q == BST_LAST) | in_tlast;

  always_comb begin
    state_d        = state_q;
    off_cnt_d      = off_cnt_q;
    hold_cnt_d     = hold_cnt_q;
    beat_cnt_d     = beat_cnt_q;
    burst_count_d  = burst_count_q;
    missed_count_d = missed_count_q;
    truncated_d    = truncated_q;
    case (state_q)
      IDLE: begin
        if (peak_stb) begin
          state_d    = (OFFSET == 0) ? CAPTURE : DELAY;
          off_cnt_d  = '0;
          beat_cnt_d = '0;
        end
      end
      DELAY: begin
        if (accept) begin
          if (off_cnt_q == OFF_LAST) begin
            state_d   = CAPTURE;
            off_cnt_d = '0;
          end else begin
            off_cnt_d = off_cnt_q + OFF_W'(1);
          end
        end
      end
      CAPTURE: begin
        if (accept) begin
          if (cap_last) begin
            state_d       = (HOLDOFF == 0) ? IDLE : HOLD;
            beat_cnt_d    = '0;
            hold_cnt_d    = '0;
            burst_count_d = burst_count_q + STAT_W'(1);
            // in_tlast landing exactly on the final beat is a complete burst
            if (beat_cnt_q != BST_LAST) truncated_d = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + BST_W'(1);
          end
        end
      end
      HOLD: begin
        if (accept) begin
          if (hold_cnt_q == HLD_LAST) begin
            state_d    = IDLE;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + OFF_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (peak_stb && (state_q != IDLE) && (missed_count_q != {STAT_W{1'b1}}))
      missed_count_d = missed_count_q + STAT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      off_cnt_q      <= '0;
      hold_cnt_q     <= '0;
      beat_cnt_q     <= '0;
      burst_count_q  <= '0;
      missed_count_q <= '0;
      truncated_q    <= 1'b0;
    end else if (clear) begin
      state_q        <= IDLE;
      off_cnt_q      <= '0;
      hold_cnt_q     <= '0;
      beat_cnt_q     <= '0;
      burst_count_q  <= '0;
      missed_count_q <= '0;
      truncated_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      off_cnt_q      <= off_cnt_d;
      hold_cnt_q     <= hold_cnt_d;
      beat_cnt_q     <= beat_cnt_d;
      burst_count_q  <= burst_count_d;
      missed_count_q <= missed_count_d;
      truncated_q    <= truncated_d;
    end
  end

  axis_out_reg #(
    .WIDTH(2 * DATA_WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (reset),
    .clear_i   (clear),
    .s_tdata_i (in_tdata),
    .s_tlast_i (cap_last),
    .s_tvalid_i((state_q == CAPTURE) & in_tvalid),
    .s_tready_o(reg_ready),
    .m_tdata_o (out_tdata),
    .m_tlast_o (out_tlast),
    .m_tvalid_o(out_tvalid),
    .m_tready_i(out_tready)
  );

  assign busy         = (state_q != IDLE);
  assign burst_count  = burst_count_q;
  assign missed_count = missed_count_q;
  assign truncated    = truncated_q;

endmodule

// File: tb/tb_preamble_burst_gate.sv
// Directed bench for preamble_burst_gate: one instance with offset/holdoff,
// one with both zero, driven from a shared ramp stream.
module tb_preamble_burst_gate;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, clear, in_tvalid, in_tlast, out_tready, peak_a, peak_z;
  logic [31:0] in_tdata;

  logic        in_tready_a, out_tvalid_a, out_tlast_a, busy_a, truncated_a;
  logic [31:0] out_tdata_a;
  logic [15:0] burst_count_a, missed_count_a;
  logic        in_tready_z, out_tvalid_z, out_tlast_z, busy_z, truncated_z;
  logic [31:0] out_tdata_z;
  logic [15:0] burst_count_z, missed_count_z;

  preamble_burst_gate #(
    .DATA_WIDTH(16), .MAX_OFFSET(4095), .OFFSET(4),
    .MAX_BURST(65535), .BURST_LEN(8), .HOLDOFF(3)
  ) u_a (
    .clk(clk), .reset(reset), .clear(clear),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tready(in_tready_a),
    .peak_stb(peak_a),
    .out_tdata(out_tdata_a), .out_tvalid(out_tvalid_a), .out_tlast(out_tlast_a), .out_tready(out_tready),
    .busy(busy_a), .burst_count(burst_count_a), .missed_count(missed_count_a), .truncated(truncated_a)
  );

  preamble_burst_gate #(
    .DATA_WIDTH(16), .MAX_OFFSET(4095), .OFFSET(0),
    .MAX_BURST(65535), .BURST_LEN(8), .HOLDOFF(0)
  ) u_z (
    .clk(clk), .reset(reset), .clear(clear),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tready(in_tready_z),
    .peak_stb(peak_z),
    .out_tdata(out_tdata_z), .out_tvalid(out_tvalid_z), .out_tlast(out_tlast_z), .out_tready(out_tready),
    .busy(busy_z), .burst_count(burst_count_z), .missed_count(missed_count_z), .truncated(truncated_z)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] got_a[$], got_z[$];
  logic        gotl_a[$], gotl_z[$];
  int rdy_err, first_busy, last_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Records output transfers happening at the coming edge, then advances.
  task automatic step();
    if (out_tvalid_a && out_tready) begin
      got_a.push_back(out_tdata_a);
      gotl_a.push_back(out_tlast_a);
    end
    if (out_tvalid_z && out_tready) begin
      got_z.push_back(out_tdata_z);
      gotl_z.push_back(out_tlast_z);
    end
    @(posedge clk);
    #1;
  endtask

  // Presents ramp samples 0..nsamp-1; triggers/tlast given as sample-index masks.
  task automatic drive(input int nsamp, input logic [63:0] trig_a, input logic [63:0] trig_z,
                       input logic [63:0] last_at, input bit bp, input int cap_lo,
                       input int cap_hi, input bit sel_z, input bit drain);
    int smp;
    int cyc;
    logic [63:0] pulsed;
    bit acc;
    bit exp_rdy;
    smp = 0;
    cyc = 0;
    pulsed = '0;
    got_a.delete(); gotl_a.delete(); got_z.delete(); gotl_z.delete();
    rdy_err = 0; first_busy = -1; last_busy = -1;
    out_tready = 1'b1;
    while (smp < nsamp && cyc < 8 * nsamp + 20) begin
      in_tvalid = 1'b1;
      in_tdata  = {smp[15:0], smp[15:0]};
      in_tlast  = last_at[smp];
      peak_a    = trig_a[smp] && !pulsed[smp];
      peak_z    = trig_z[smp] && !pulsed[smp];
      pulsed[smp] = 1'b1;
      out_tready = bp ? ~out_tready : 1'b1;
      #1;
      exp_rdy = !(smp >= cap_lo && smp <= cap_hi && out_tvalid_a && !out_tready);
      if (in_tready_a !== exp_rdy) rdy_err++;
      if (busy_a) begin
        if (first_busy < 0) first_busy = smp;
        last_busy = smp;
      end
      acc = sel_z ? in_tready_z : in_tready_a;
      step();
      if (acc) smp++;
      cyc++;
    end
    if (smp < nsamp) check("drive_timeout", smp, nsamp);
    in_tvalid = 1'b0; in_tlast = 1'b0; peak_a = 1'b0; peak_z = 1'b0; out_tready = 1'b1;
    if (drain) repeat (4) step();
  endtask

  // Expects consecutive ramp samples first..first+n-1, tlast only on the final one.
  task automatic check_seq(input string tag, input bit sel_z, input int qofs,
                           input int first, input int n);
    int sz;
    sz = sel_z ? got_z.size() : got_a.size();
    for (int i = 0; i < n && qofs + i < sz; i++) begin
      logic [31:0] d;
      logic        l;
      logic [15:0] s;
      d = sel_z ? got_z[qofs + i] : got_a[qofs + i];
      l = sel_z ? gotl_z[qofs + i] : gotl_a[qofs + i];
      s = 16'(first + i);
      check({tag, "_data"}, d, {s, s});
      check({tag, "_last"}, {31'd0, l}, (i == n - 1) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; clear = 1'b0; in_tvalid = 1'b0; in_tlast = 1'b0; in_tdata = '0;
    out_tready = 1'b1; peak_a = 1'b0; peak_z = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("rst_in_tready", in_tready_a, 1);
    check("rst_out_tvalid", out_tvalid_a, 0);
    check("rst_out_tlast", out_tlast_a, 0);
    check("rst_out_tdata", out_tdata_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_burst_count", burst_count_a, 0);
    check("rst_missed_count", missed_count_a, 0);
    check("rst_truncated", truncated_a, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    step();

    // Basic burst: trigger at sample 10 -> samples 15..22, busy 11..25
    drive(30, 64'd1 << 10, 64'd0, 64'd0, 1'b0, 15, 22, 1'b0, 1'b1);
    check("basic_beats", got_a.size(), 8);
    check_seq("basic", 1'b0, 0, 15, 8);
    check("basic_burst_count", burst_count_a, 1);
    check("basic_missed", missed_count_a, 0);
    check("basic_truncated", truncated_a, 0);
    check("basic_busy_rise", first_busy, 11);
    check("basic_busy_fall", last_busy, 25);
    check("basic_busy_end", busy_a, 0);
    check("basic_ready_err", rdy_err, 0);

    // Output backpressure: identical burst, in_tready follows register occupancy
    pulse_clear();
    check("clear_burst_count", burst_count_a, 0);
    drive(30, 64'd1 << 10, 64'd0, 64'd0, 1'b1, 15, 22, 1'b0, 1'b1);
    check("bp_beats", got_a.size(), 8);
    check_seq("bp", 1'b0, 0, 15, 8);
    check("bp_burst_count", burst_count_a, 1);
    check("bp_busy_fall", last_busy, 25);
    check("bp_ready_err", rdy_err, 0);

    // Triggers in DELAY(12), CAPTURE(17), HOLD(24); in_tlast outside CAPTURE ignored
    pulse_clear();
    drive(30, (64'd1 << 10) | (64'd1 << 12) | (64'd1 << 17) | (64'd1 << 24), 64'd0,
          (64'd1 << 12) | (64'd1 << 24), 1'b0, 15, 22, 1'b0, 1'b1);
    check("busy_beats", got_a.size(), 8);
    check_seq("busy", 1'b0, 0, 15, 8);
    check("busy_missed", missed_count_a, 3);
    check("busy_burst_count", burst_count_a, 1);
    check("busy_truncated", truncated_a, 0);

    // Truncation on 5th capture beat (sample 19)
    pulse_clear();
    drive(30, 64'd1 << 10, 64'd0, 64'd1 << 19, 1'b0, 15, 19, 1'b0, 1'b1);
    check("trunc_beats", got_a.size(), 5);
    check_seq("trunc", 1'b0, 0, 15, 5);
    check("trunc_flag", truncated_a, 1);
    check("trunc_burst_count", burst_count_a, 1);
    check("trunc_busy_fall", last_busy, 22);

    // Reset mid-capture after samples 15,16,17 accepted
    drive(18, (64'd1 << 10) | (64'd1 << 12), 64'd0, 64'd0, 1'b0, 15, 17, 1'b0, 1'b0);
    check("pre_rst_delivered", got_a.size(), 2);
    check("pre_rst_tvalid", out_tvalid_a, 1);
    check("pre_rst_missed", missed_count_a, 1);
    reset = 1'b0;
    #1;
    check("midrst_tvalid", out_tvalid_a, 0);
    check("midrst_tlast", out_tlast_a, 0);
    check("midrst_tdata", out_tdata_a, 0);
    check("midrst_busy", busy_a, 0);
    check("midrst_burst_count", burst_count_a, 0);
    check("midrst_missed", missed_count_a, 0);
    check("midrst_truncated", truncated_a, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    step();
    drive(30, 64'd1 << 10, 64'd0, 64'd0, 1'b0, 15, 22, 1'b0, 1'b1);
    check("postrst_beats", got_a.size(), 8);
    check_seq("postrst", 1'b0, 0, 15, 8);
    check("postrst_burst_count", burst_count_a, 1);

    // Zero offset/holdoff: triggers at 10 and 19 -> 11..18 then 20..27
    pulse_clear();
    drive(36, 64'd0, (64'd1 << 10) | (64'd1 << 19), 64'd0, 1'b0, 100, 100, 1'b1, 1'b1);
    check("zero_beats", got_z.size(), 16);
    check_seq("zero_b1", 1'b1, 0, 11, 8);
    check_seq("zero_b2", 1'b1, 8, 20, 8);
    check("zero_burst_count", burst_count_z, 2);
    check("zero_missed", missed_count_z, 0);
    check("zero_truncated", truncated_z, 0);
    check("zero_busy_end", busy_z, 0);
    check("zero_other_idle", got_a.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/preamble_burst_gate.md
# preamble_burst_gate

Consumes the decimated IQ stream together with the preamble detector's `peak_stb` and emits exactly one framed burst per detected preamble. After a trigger it skips a fixed number of samples, forwards a fixed-length burst with `out_tlast` on its final beat, and then ignores further triggers for a holdoff window. It sits directly downstream of `preamble_detect` and feeds the RX framing and DMA path.

## Interface

**Parameters**
- `DATA_WIDTH`, 16: width of each I or Q component.
- `MAX_OFFSET`, 4095: maximum value of `OFFSET`; sets the width of the offset counter.
- `OFFSET`, 4092: number of accepted input beats dropped between the trigger and the first burst beat.
- `MAX_BURST`, 65535: maximum value of `BURST_LEN`; sets the width of the burst counter.
- `BURST_LEN`, 1024: number of beats forwarded per burst. Must be at least 1.
- `HOLDOFF`, 256: number of accepted input beats dropped after a burst, with triggers ignored.

**Ports**
- `clk`, input, 1: the single clock.
- `reset`, input, 1: asynchronous, active-low.
- `clear`, input, 1: synchronous clear, active-high. Same effect as reset.
- `in_tdata`, input, 2*DATA_WIDTH: {I, Q}.
- `in_tvalid`, input, 1
- `in_tlast`, input, 1
- `in_tready`, output, 1
- `peak_stb`, input, 1: single-cycle trigger pulse.
- `out_tdata`, output, 2*DATA_WIDTH
- `out_tvalid`, output, 1
- `out_tlast`, output, 1
- `out_tready`, input, 1
- `busy`, output, 1: high in any state other than IDLE.
- `burst_count`, output, 16: number of completed bursts. Wraps.
- `missed_count`, output, 16: number of triggers ignored while busy. Saturates at 0xFFFF.
- `truncated`, output, 1: sticky flag, set when a burst is cut short by `in_tlast`.

## Operation

- An input beat is "accepted" when `in_tvalid & in_tready`.
- The state machine has four states: IDLE, DELAY, CAPTURE, HOLD.
- **IDLE**
  - `in_tready` = 1; all beats are dropped.
  - `peak_stb` moves to DELAY, or to CAPTURE if `OFFSET`=0.
  - A beat accepted in the same cycle as `peak_stb` is dropped and not counted toward the offset.
- **DELAY**
  - `in_tready` = 1.
  - Counts accepted beats. The `OFFSET`-th accepted beat is dropped and the state moves to CAPTURE.
- **CAPTURE**
  - Accepted beats are loaded into the output register.
  - The `BURST_LEN`-th beat is loaded with `out_tlast`=1. The state then moves to HOLD, or to IDLE if `HOLDOFF`=0, and `burst_count` increments.
  - If `in_tlast`=1 arrives on an earlier beat, that beat gets `out_tlast`=1, `truncated` is set, and the state moves on as for a complete burst. `burst_count` still increments.
- **HOLD**
  - `in_tready` = 1; beats are dropped.
  - After `HOLDOFF` accepted beats the state returns to IDLE.
- **Missed triggers:** `peak_stb` in DELAY, CAPTURE or HOLD increments `missed_count` and has no other effect.
- **`in_tlast` outside CAPTURE** is ignored.
- **Counter widths:**
  - Offset counter is $clog2(MAX_OFFSET+1) bits.
  - Burst counter is $clog2(MAX_BURST+1) bits.
  - Holdoff counter is $clog2(MAX_OFFSET+1) bits.
  - All counters are compared against `OFFSET-1`, `BURST_LEN-1` and `HOLDOFF-1`, so they never wrap.
- **Reset or clear mid-burst:**
  - Returns to IDLE and empties the output register.
  - Zeroes `burst_count`, `missed_count` and `truncated`.
  - No trailing `out_tlast` is emitted.

## Timing

- **Reset values:**
  - `in_tready`=1 (IDLE).
  - `out_tvalid`=0, `out_tlast`=0, `out_tdata`=0.
  - `busy`=0, `burst_count`=0, `missed_count`=0, `truncated`=0.
- **State entry:** a trigger at cycle t makes `busy`=1 at t+1. In the cycle that holds `peak_stb`, DELAY counting has not started.
- **Latency:** one output register stage. A beat accepted in CAPTURE at cycle t appears on `out_*` at t+1.
- **`in_tready` in CAPTURE** = `~out_tvalid | out_tready`. Full throughput with `out_tready` held high.
- **Output hold:** `out_tvalid`, `out_tdata` and `out_tlast` are held stable until `out_tready`.
- **Leaving CAPTURE:** after the last beat the state is DELAY/HOLD/IDLE. Beats are dropped at full rate while the registered last beat waits for `out_tready`; that beat is not lost.
- **Trigger during drain:** a trigger arriving in IDLE while the output register still holds the last beat is accepted. The next burst's first beat waits for the register to drain.
- **Status timing:** `burst_count` and `truncated` update on the cycle after the final beat is accepted, not when it is delivered.

## Structure

- **Shared package `preamble_pkg`:**
  - State enum: IDLE=2'd0, DELAY=2'd1, CAPTURE=2'd2, HOLD=2'd3.
  - Counter width helper constants.
  - Also used by `preamble_detect` users.
- **Sub-module:** one, `axis_out_reg`. It is a single-entry AXI-stream register with tdata/tlast, occupancy-gated ready and synchronous clear. The FSM and counters stay in the top level.

## Test plan

- **Basic burst:** `OFFSET`=4, `BURST_LEN`=8, `HOLDOFF`=3, ramp data 0,1,2,…, `peak_stb` pulsed at sample 10 → output carries samples 15..22, `out_tlast` only on 22, `burst_count`=1, `busy` falls after sample 25.
- **Output backpressure:** same burst with `out_tready` toggling 1/0 every cycle → output order, data and `out_tlast` are identical, and `in_tready` is low exactly when the register is full and not ready.
- **Triggers while busy:** `peak_stb` pulsed during DELAY, CAPTURE and HOLD → a single burst is produced and `missed_count`=3.
- **Truncation:** `in_tlast` on the 5th capture beat with `BURST_LEN`=8 → 5 beats out, `out_tlast` on the 5th, `truncated`=1, `burst_count`=1.
- **Reset mid-capture:** `reset` asserted low asynchronously after 3 burst beats → `out_tvalid`=0 immediately, all counters 0, and the next trigger yields a full clean burst.
- **Zero offset/holdoff:** `OFFSET`=0, `HOLDOFF`=0, two triggers 9 samples apart with `BURST_LEN`=8 → two back-to-back bursts, no missed triggers, `burst_count`=2.
